program_sequencer: RTL
======================

# program_sequencer

Upstream instruction feeder for the processor `top`. It holds a loadable program memory and presents instruction and immediate words on the processor's `din` input. It drives `run` and tracks the processor's `done` so that each word is on `din` in the cycle the processor samples it. It also provides a run/halt handshake to the host, plus a watchdog and an instruction count.

## Interface
- REG_WIDTH, 16, width of `din` and memory words
- INSTRUCTION_WIDTH, 9, instruction field in `din[INSTRUCTION_WIDTH-1:0]`: {opcode[8:6], dest[5:3], src[2:0]}
- DEPTH, 16, program memory words (power of 2)
- ADDR_WIDTH, 4, log2(DEPTH)
- WDOG_CYCLES, 8, maximum cycles waited for `proc_done` per instruction
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_en  in  1  write `load_data` to `mem[load_addr]`; ignored while busy
- load_addr  in  ADDR_WIDTH  write address
- load_data  in  REG_WIDTH  write data
- prog_len  in  ADDR_WIDTH+1  number of valid words (0..DEPTH), sampled on accepted start
- start  in  1  one-cycle pulse, begin execution at address 0; ignored while busy
- proc_done  in  1  processor `done`
- din  out  REG_WIDTH  word to processor
- run  out  1  processor `run`
- busy  out  1  sequencer not idle
- halted  out  1  one-cycle pulse on normal completion
- error  out  1  sticky until next accepted start or reset
- instr_count  out  ADDR_WIDTH+1  instructions completed since last start

## Operation
- Memory: register array with asynchronous read. Not cleared by reset; contents persist across runs.
- Opcodes: 000 MV, 001 MVI (two words: instruction, then immediate), 010 ADD, 011 SUB. Other opcodes are treated as single-word.
- States: IDLE, FETCH, IMM, WAIT.
- IDLE:
  - An accepted start latches `prog_len` into `len_q` and clears pc, `instr_count` and `error`.
  - If `len_q`==0, pulse `halted` and stay IDLE. Otherwise go to FETCH.
- FETCH:
  - Outputs: `din`=`mem[pc]`, `run`=1.
  - Next state is IMM if the opcode is MVI, else WAIT. pc increments by 1.
  - If the opcode is MVI and pc+1 == `len_q` (missing immediate), set `error` and go to IDLE without asserting `halted`.
- IMM:
  - Outputs: `din`=`mem[pc]`, `run`=0.
  - On a cycle with `proc_done`=1: pc increments, `instr_count` increments, then go to FETCH, or to IDLE with `halted` if pc+1 == `len_q`.
- WAIT:
  - Outputs: `din`=0, `run`=0.
  - On `proc_done`=1: `instr_count` increments, then go to FETCH, or to IDLE with `halted` if pc == `len_q`.
- Watchdog:
  - A counter clears on entry to IMM/WAIT and increments each cycle there without `proc_done`.
  - When it reaches WDOG_CYCLES, set `error`, go to IDLE, no `halted`.
- `busy` = (state != IDLE).
- Width rules: pc and `instr_count` compare against `len_q` at ADDR_WIDTH+1 bits. `prog_len` > DEPTH is clamped to DEPTH.

## Timing
- Reset values: state IDLE, pc 0, `din` 0, `run` 0, `busy` 0, `halted` 0, `error` 0, `instr_count` 0. Reset mid-program aborts immediately; memory is unaffected.
- Start accepted at edge N puts FETCH in cycle N+1. The processor latches the instruction at the end of that cycle (its t0).
- MVI: the immediate is on `din` during processor t1, concurrent with `proc_done`. The next FETCH follows in the cycle after `proc_done`, with no idle cycle.
- Per-instruction occupancy on the `din`/`run` side:
  - MV: 2 cycles
  - MVI: 2 cycles
  - ADD/SUB: 4 cycles
- `proc_done` is ignored in IDLE and FETCH.
- A `load_en` coincident with an accepted start: the write happens and start is accepted in the same cycle.
- `halted` is high for exactly one cycle, in the cycle after the final `proc_done`.

## Test plan
- Load `mem[0..1]`={0x040, 0x0005}, `prog_len`=2, start, bench models processor timing:
  - FETCH: `din`=0x040, `run`=1.
  - Next cycle: `din`=0x0005 with `proc_done`.
  - Result: `halted` pulse, `instr_count`=1, `error`=0.
- Program {0x060, 0x0005, 0x068, 0x0003, 0x0A5, 0x0E5} (MVI R4,5; MVI R5,3; ADD R4,R5; SUB R4,R5) with `prog_len`=6, driving the real `top`:
  - Processor bus shows 0x0008, then 0x0005.
  - `instr_count`=4, `halted` pulses once.
  - Total busy cycles = 12.
- `prog_len`=0, start: `halted` in the cycle after start, `busy` never 1, `din`=0 throughout.
- `prog_len`=1 with `mem[0]`=0x040 (MVI missing immediate): `error`=1 after the FETCH cycle, no `halted`, `busy`=0.
- `mem[0]`=0x0A5, `proc_done` held 0: `error` set after 8 cycles in WAIT, return to IDLE. A following start clears `error`.
- Assert `rst` during WAIT of the second instruction: all outputs 0 immediately. A restart re-executes from address 0 with memory intact.

Source files
------------

// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
//
// Instruction feeder for the processor. A small program memory is loaded by
// the host while the sequencer is idle; on start, the words are presented on
// din one per processor step, with run asserted for the instruction word.
// The processor's done is tracked so the next instruction follows as soon as
// the previous one retires. A watchdog bounds the wait for done.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   load_en      write load_data to mem[load_addr] (idle only)
//   load_addr    memory write address
//   load_data    memory write data
//   prog_len     number of valid program words, sampled on accepted start
//   start        begin execution at address 0 (idle only)
//   proc_done    processor done
//   din          word to processor (0 when nothing is presented)
//   run          processor run, high in the instruction-fetch cycle
//   busy         sequencer not idle
//   halted       one-cycle pulse after the final instruction retires
//   error        sticky fault flag (missing immediate or watchdog expiry)
//   instr_count  instructions completed since the last start
// -----------------------------------------------------------------------------
module program_sequencer #(
   parameter int REG_WIDTH         = 16,
   parameter int INSTRUCTION_WIDTH = 9,
   parameter int DEPTH             = 16,
   parameter int ADDR_WIDTH        = 4,
   parameter int WDOG_CYCLES       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [REG_WIDTH-1:0]  load_data,
   input  logic [ADDR_WIDTH:0]   prog_len,
   input  logic                  start,
   input  logic                  proc_done,
   output logic [REG_WIDTH-1:0]  din,
   output logic                  run,
   output logic                  busy,
   output logic                  halted,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   instr_count
);

   localparam int WD_W = $clog2(WDOG_CYCLES + 1);

   localparam logic [ADDR_WIDTH:0] PC_ZERO = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0] PC_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [WD_W-1:0]     WD_ZERO = {WD_W{1'b0}};
   localparam logic [WD_W-1:0]     WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
   localparam logic [WD_W-1:0]     WD_MAX  = WD_W'(WDOG_CYCLES);
   localparam logic [2:0]          OP_MVI  = 3'b001;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FETCH = 2'b01,
      S_IMM   = 2'b10,
      S_WAIT  = 2'b11
   } state_t;

   // Program memory: no reset, contents survive across runs and resets.
   logic [REG_WIDTH-1:0] mem_q [DEPTH];

   state_t               state_q, state_d;
   logic [ADDR_WIDTH:0]  pc_q, pc_d;
   logic [ADDR_WIDTH:0]  len_q, len_d;
   logic [ADDR_WIDTH:0]  cnt_q, cnt_d;
   logic [WD_W-1:0]      wdog_q, wdog_d;
   logic                 err_q, err_d;
   logic                 halted_q, halted_d;
   logic                 run_q, run_d;
   logic                 busy_q, busy_d;
   logic [REG_WIDTH-1:0] din_q, din_d;

   logic                 mem_we_s;
   logic [ADDR_WIDTH:0]  len_clamp_s;
   logic [ADDR_WIDTH:0]  pc_inc_s;
   logic [WD_W-1:0]      wdog_inc_s;
   logic [2:0]           op_s;
   logic [REG_WIDTH-1:0] rd_word_s;

   assign din         = din_q;
   assign run         = run_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign error       = err_q;
   assign instr_count = cnt_q;

   // Host writes land only while idle, so the memory is static during a run.
   assign mem_we_s    = load_en && (state_q == S_IDLE);
   assign len_clamp_s = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
   assign pc_inc_s    = pc_q + PC_ONE;
   assign wdog_inc_s  = wdog_q + WD_ONE;
   assign op_s        = mem_q[pc_q[ADDR_WIDTH-1:0]][INSTRUCTION_WIDTH-1 -: 3];

   // Program memory write port.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[load_addr] <= load_data;
      end
   end

   // Next-state, program counter, counters and status flags.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      wdog_d   = wdog_q;
      err_d    = err_q;
      halted_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d = len_clamp_s;
               pc_d  = PC_ZERO;
               cnt_d = PC_ZERO;
               err_d = 1'b0;
               if (len_clamp_s == PC_ZERO) begin
                  // Empty program completes immediately.
                  halted_d = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_FETCH: begin
            pc_d   = pc_inc_s;
            wdog_d = WD_ZERO;
            if (op_s == OP_MVI) begin
               if (pc_inc_s == len_q) begin
                  // MVI is the last word: its immediate lies outside the program.
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_IMM;
               end
            end else begin
               state_d = S_WAIT;
            end
         end

         S_IMM: begin
            if (proc_done) begin
               // The immediate is consumed along with done, so step past it.
               pc_d  = pc_inc_s;
               cnt_d = cnt_q + PC_ONE;
               if (pc_inc_s == len_q) begin
                  halted_d = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  state_d = S_FETCH;
               end
            end else if (wdog_inc_s == WD_MAX) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wdog_d = wdog_inc_s;
            end
         end

         S_WAIT: begin
            if (proc_done) begin
               cnt_d = cnt_q + PC_ONE;
               if (pc_q == len_q) begin
                  halted_d = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  state_d = S_FETCH;
               end
            end else if (wdog_inc_s == WD_MAX) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wdog_d = wdog_inc_s;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output words for the next cycle, computed from the next state so that
   // din/run/busy can be registered without adding latency.
   always_comb begin
      rd_word_s = mem_q[pc_d[ADDR_WIDTH-1:0]];
      // A write accepted together with start must be visible in the first fetch.
      if (mem_we_s && (load_addr == pc_d[ADDR_WIDTH-1:0])) begin
         rd_word_s = load_data;
      end else begin
         rd_word_s = mem_q[pc_d[ADDR_WIDTH-1:0]];
      end

      if ((state_d == S_FETCH) || (state_d == S_IMM)) begin
         din_d = rd_word_s;
      end else begin
         din_d = {REG_WIDTH{1'b0}};
      end

      run_d  = (state_d == S_FETCH);
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= PC_ZERO;
         len_q    <= PC_ZERO;
         cnt_q    <= PC_ZERO;
         wdog_q   <= WD_ZERO;
         err_q    <= 1'b0;
         halted_q <= 1'b0;
         run_q    <= 1'b0;
         busy_q   <= 1'b0;
         din_q    <= {REG_WIDTH{1'b0}};
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         wdog_q   <= wdog_d;
         err_q    <= err_d;
         halted_q <= halted_d;
         run_q    <= run_d;
         busy_q   <= busy_d;
         din_q    <= din_d;
      end
   end

endmodule
